// File: rtl/abuf2ddr.sv
// abuf2ddr: accumulation-buffer write-back. On start, reads R rows from each
// of the four accum banks (bank-major) into a 2-row staging buffer and
// serialises each row as 1, 2 or 3 DDR beats on a valid/ready stream.

package GLOBAL_PARAM;
  localparam int BATCH  = 16;
  localparam int DATA_W = 32;
  localparam int TAIL_W = 64;
  localparam int ROW_DATA_W = BATCH * DATA_W;
  localparam int ROW_TAIL_W = BATCH * TAIL_W;
endpackage

module abuf2ddr #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  parameter int DDR_W     = 512
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  output logic                                        done,
  input  logic [1:0]                                  conf_trans_type,
  input  logic [7:0]                                  conf_trans_num,
  output logic [3:0][ADDR_W-1:0]                      abuf_rd_addr,
  output logic [3:0]                                  abuf_rd_en,
  input  logic [3:0][GLOBAL_PARAM::ROW_DATA_W-1:0]    abuf_rd_data,
  input  logic [3:0][GLOBAL_PARAM::ROW_TAIL_W-1:0]    abuf_rd_tail,
  output logic [DDR_W-1:0]                            ddr_data,
  output logic                                        ddr_valid,
  input  logic                                        ddr_ready,
  output logic                                        ddr_last
);

  localparam int DW = GLOBAL_PARAM::ROW_DATA_W;
  localparam int TW = GLOBAL_PARAM::ROW_TAIL_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [1:0]        ttype;     // normalised: 0 data, 1 data+tail, 2 tail
  logic [7:0]        num;       // rows per bank minus 1
  logic [1:0]        bpr_m1;    // beats per row minus 1
  logic [11:0]       total_m1;  // index of the final beat

  logic [ADDR_W-1:0] row;
  logic [1:0]        bank;
  logic              rd_pend;   // read issued last cycle, data on the bus now
  logic [1:0]        pend_bank;

  logic [1:0][DW-1:0] stg_data;
  logic [1:0][TW-1:0] stg_tail;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         cnt;      // rows held in staging

  logic [1:0]  bidx;            // beat within the head row
  logic [11:0] out_cnt;         // beats handed off so far

  logic        start_ok, xfer, row_end, issue, last_rd;
  logic [2:0]  occ;
  logic [1:0]  n_type, n_bpr_m1;
  logic [11:0] n_total_m1;

  assign start_ok = (state == IDLE) && start;
  assign xfer     = ddr_valid && ddr_ready;
  assign row_end  = xfer && (bidx == bpr_m1);
  // Rows that will occupy staging at the end of this cycle, counting the
  // pending read landing and the head row leaving on this handshake. A new
  // read lands one cycle later, so it is safe whenever this is below 2.
  assign occ      = {1'b0, cnt} + {2'b0, rd_pend} - {2'b0, row_end};
  assign issue    = (state == RUN) && (occ < 3'd2);
  assign last_rd  = (bank == 2'd3) && (row == ADDR_W'(num));

  assign ddr_valid = (cnt != 2'd0);
  assign ddr_last  = ddr_valid && (out_cnt == total_m1);

  // Config decode for the value latched at start (type 11 behaves as 00).
  always_comb begin
    n_type = (conf_trans_type == 2'b11) ? 2'b00 : conf_trans_type;
    case (n_type)
      2'd1:    n_bpr_m1 = 2'd2;
      2'd2:    n_bpr_m1 = 2'd1;
      default: n_bpr_m1 = 2'd0;
    endcase
    n_total_m1 = (((12'(conf_trans_num) + 12'd1) * (12'(n_bpr_m1) + 12'd1)) << 2) - 12'd1;
  end

  // Per-bank read port: only the bank currently being walked sees the strobe.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    assign abuf_rd_en[b]   = issue && (bank == 2'(b));
    assign abuf_rd_addr[b] = (bank == 2'(b)) ? row : '0;
  end

  // Head-row beat select.
  always_comb begin
    ddr_data = stg_data[rd_ptr];
    case (ttype)
      2'd1: case (bidx)
              2'd0:    ddr_data = stg_data[rd_ptr];
              2'd1:    ddr_data = stg_tail[rd_ptr][DDR_W-1:0];
              default: ddr_data = stg_tail[rd_ptr][2*DDR_W-1:DDR_W];
            endcase
      2'd2: ddr_data = (bidx == 2'd0) ? stg_tail[rd_ptr][DDR_W-1:0]
                                      : stg_tail[rd_ptr][2*DDR_W-1:DDR_W];
      default: ddr_data = stg_data[rd_ptr];
    endcase
  end

  // Control FSM: latches config on start, registers the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      ttype    <= 2'd0;
      num      <= 8'd0;
      bpr_m1   <= 2'd0;
      total_m1 <= 12'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          ttype    <= n_type;
          num      <= conf_trans_num;
          bpr_m1   <= n_bpr_m1;
          total_m1 <= n_total_m1;
        end
        RUN:   if (issue && last_rd) state <= DRAIN;
        DRAIN: if (xfer && ddr_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read address walk: row-major within bank, wraps to bank 0 row 0 at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      bank      <= 2'd0;
      rd_pend   <= 1'b0;
      pend_bank <= 2'd0;
    end else begin
      rd_pend   <= issue;
      pend_bank <= bank;
      if (start_ok) begin
        row  <= '0;
        bank <= 2'd0;
      end else if (issue) begin
        if (row == ADDR_W'(num)) begin
          row  <= '0;
          bank <= bank + 2'd1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

  // Staging buffer: capture landing rows, release the head on its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_data <= '0;
      stg_tail <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      cnt <= cnt + {1'b0, rd_pend} - {1'b0, row_end};
      if (rd_pend) begin
        stg_data[wr_ptr] <= abuf_rd_data[pend_bank];
        stg_tail[wr_ptr] <= abuf_rd_tail[pend_bank];
        wr_ptr           <= ~wr_ptr;
      end
      if (row_end) rd_ptr <= ~rd_ptr;
    end
  end

  // Output beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx    <= 2'd0;
      out_cnt <= 12'd0;
    end else if (start_ok) begin
      bidx    <= 2'd0;
      out_cnt <= 12'd0;
    end else if (xfer) begin
      bidx    <= row_end ? 2'd0 : bidx + 2'd1;
      out_cnt <= out_cnt + 12'd1;
    end
  end

endmodule

// File: doc/abuf2ddr.md
# abuf2ddr

Write-back stage for the accumulation buffers: on `start`, reads rows from the four accumulation-buffer banks and serialises them onto the DDR write data stream with a valid/ready handshake. It sits directly downstream of the accum buffers that `ddr2abuf` fills. It moves finished (or partial) accumulation results, meaning data and/or tails, back to DDR under control of the layer sequencer.

## Interface
Parameters:
- `BUF_DEPTH`, 256: rows per bank.
- `ADDR_W`, `bw(BUF_DEPTH)`: row address width.
- `DDR_W`, 512: DDR stream width.
- `BATCH`, `DATA_W`, `TAIL_W`: taken from `GLOBAL_PARAM`. Required: `BATCH*DATA_W == DDR_W` and `BATCH*TAIL_W == 2*DDR_W`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; ignored unless idle.
- `done` out 1: one-cycle pulse after the final beat handshake.
- `conf_trans_type` in 2: 00 data only, 01 data+tail, 10 tail only, 11 treated as 00.
- `conf_trans_num` in 8: rows per bank minus 1.
- `abuf_rd_addr` out [4][ADDR_W]: per-bank row address.
- `abuf_rd_en` out [4]: per-bank read strobe.
- `abuf_rd_data` in [4][BATCH*DATA_W]: valid 1 cycle after `abuf_rd_en`.
- `abuf_rd_tail` in [4][BATCH*TAIL_W]: valid 1 cycle after `abuf_rd_en`.
- `ddr_data` out DDR_W: write beat.
- `ddr_valid` out 1: beat valid.
- `ddr_ready` in 1: sink accepts.
- `ddr_last` out 1: marks the final beat of the transfer.

## Operation
- Config is latched at `start`. Mid-transfer config changes have no effect.
- Rows per bank: R = `conf_trans_num`+1. Range 1..256, and R ≤ BUF_DEPTH.
- Order is bank-major: bank 0 rows 0..R-1, then bank 1, bank 2, bank 3.
- Beats per row, B:
  - type 00: data, so B=1.
  - type 01: data, tail[DDR_W-1:0], tail[2*DDR_W-1:DDR_W], so B=3.
  - type 10: tail low, tail high, so B=2.
- Total beats: 4·R·B.
- Only the bank being read has `abuf_rd_en` high. At most one read is issued per cycle.
- Staging is a 2-row buffer (data and tail). A read is issued only if the free slots minus in-flight reads is at least 1, so the buffer never overflows under any `ddr_ready` pattern.
- FSM:
  - IDLE: on `start`, go to RUN.
  - RUN: issues reads. After the last read is issued, go to DRAIN.
  - DRAIN: waits until the last beat is accepted, then goes to DONE.
  - DONE: drives the `done` pulse, then returns to IDLE.
- Handshake:
  - A beat transfers when `ddr_valid && ddr_ready`.
  - While `ddr_valid && !ddr_ready`, `ddr_data` and `ddr_last` hold stable.
  - `ddr_valid` is never withdrawn without a handshake.
- `ddr_last` is high only on beat 4·R·B−1.
- A `start` received outside IDLE is dropped.
- Reset is asynchronous, at any time, including mid-transfer. Result: FSM returns to IDLE, staging is emptied, and all outputs go to 0 (`done`, `ddr_valid`, `ddr_last`, `abuf_rd_en`, `abuf_rd_addr`, `ddr_data`). No partial beat or `done` is produced after reset.

## Timing
- Cycle T: `start` sampled.
- T+1: first `abuf_rd_en` (bank 0, addr 0).
- T+2: row data captured into staging.
- T+3: first `ddr_valid`.
- With `ddr_ready` held high, one beat is sent per cycle with no bubbles, including across row and bank boundaries. The last beat falls at T+3+4·R·B−1.
- `done` goes high the cycle after the last handshake and lasts 1 cycle.
- The earliest next accepted `start` is the cycle after `done`.
- Address wrap: when the row counter reaches R−1, it resets to 0 and the bank index increments. Bank 3 at row R−1 ends reads.
- Reads stall while staging is full and resume the cycle a slot frees. A slot frees on the handshake of its last beat.

## Test plan
- Type 00, num=3, ready always 1:
  - 16 beats on consecutive cycles starting T+3.
  - Order: bank0 r0..r3, bank1 … bank3 r3.
  - `ddr_last` on beat 15; `done` at T+19.
- Type 01, num=0, ready always 1:
  - 12 beats; each bank gives data, tail low, tail high.
  - `abuf_rd_en` is pulsed once per bank.
- Type 10, num=255, random `ddr_ready` (50%):
  - 2048 beats, with no loss or duplication and data stable while stalled.
  - Addresses wrap 255→0 at each bank change.
  - Checked against a reference model.
- Backpressure stress, type 01, num=1:
  - `ddr_ready`=0 for 20 cycles after the first valid.
  - At most 2 reads are outstanding beyond the consumed rows.
  - Output stream resumes intact.
- `start` pulsed during RUN:
  - Ignored, and the beat count is unchanged.
- `rst` asserted at beat 5 of a type 00, num=7 transfer:
  - All outputs are 0 immediately.
  - No `done` follows.
  - A fresh `start` then produces the full 32-beat sequence from bank 0 row 0.
